alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Buffers results from the 4-bit ALU stage (`{cout,out}` plus the opcode that produced them) in a small FIFO and presents them downstream on a valid/ready handshake. It sits directly downstream of the ALU: the ALU's `enable` acts as the write strobe. The block decouples the ALU from a slower consumer, flags zero results, and records a sticky overflow when a result arrives while the buffer is full.

## Interface

Parameters:
- `DATA_W`, 4: ALU result width, excluding carry.
- `DEPTH`, 4: number of entries; must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: ALU `enable`; a result is presented this cycle.
- `in_out`, in, DATA_W: ALU `out`.
- `in_cout`, in, 1: ALU `cout`.
- `in_opcode`, in, 2: opcode that produced the result.
- `out_valid`, out, 1: head entry is available.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_data`, out, DATA_W: head result.
- `out_cout`, out, 1: head carry/borrow.
- `out_opcode`, out, 2: head opcode.
- `out_zero`, out, 1: high when `{out_cout,out_data}` == 0 and `out_valid` is high.
- `count`, out, $clog2(DEPTH)+1: number of occupied entries.
- `full`, out, 1: `count` == DEPTH.
- `empty`, out, 1: `count` == 0.
- `overflow`, out, 1: sticky; a result was dropped.
- `clr_ovf`, in, 1: clears `overflow`.

## Operation

- Entry format is `{opcode, cout, out}`, i.e. 2+1+DATA_W bits, stored in a register array indexed by `wr_ptr` and `rd_ptr`. Each pointer is log2(DEPTH) bits and wraps modulo DEPTH.
- Push occurs when `in_valid && (!full || pop)`. Pop occurs when `out_valid && out_ready`.
- Push when full without a simultaneous pop:
  - The entry is dropped; `wr_ptr` and `count` are unchanged.
  - `overflow` is set on the next edge.
- Push and pop in the same cycle:
  - Both happen; `count` is unchanged.
  - This also applies when full: the new entry takes the freed slot.
- Push and pop when empty: the pop is not possible, because `out_valid` is 0. Only the push happens.
- `out_valid` = `!empty`.
- Head outputs (`out_data`, `out_cout`, `out_opcode`) are read combinationally from `mem[rd_ptr]`. They are forced to 0 when empty.
- `overflow`:
  - Cleared by `rst` or `clr_ovf`.
  - If a set event and `clr_ovf` occur in the same cycle, set wins.
- No fall-through: a pushed entry is visible no earlier than the cycle after the push edge.
- Consumer rule: once `out_valid` is high, the head entry stays stable until it is popped.

## Timing

- Reset (`rst` high at an edge):
  - `wr_ptr`, `rd_ptr`, `count` go to 0; `empty`=1, `full`=0, `out_valid`=0, `overflow`=0.
  - All head outputs are 0 and `out_zero`=0.
  - Storage contents are don't-care.
- Reset mid-operation discards all buffered entries. A push or pop in the reset cycle is ignored.
- Write-to-read latency is 1 cycle: a push at edge N gives `out_valid`=1 after edge N when the FIFO was empty.
- Throughput: 1 push and 1 pop per cycle, sustained.
- `count`, `full`, `empty` and `overflow` are registered or derived from registered state. They update only on clock edges.
- `out_zero` is combinational from the head entry.

## Configuration

- `ALU_RES_PARITY_EN`:
  - Defined:
    - Adds output `out_parity` (1 bit), equal to the XOR-reduce of `{out_opcode,out_cout,out_data}`.
    - Parity is computed at push and stored as an extra bit per entry.
    - Reset value 0; 0 when empty.
  - Undefined: the port and the storage bit are absent; all other behaviour is identical.

## Test plan

- Reset then idle: all outputs 0 and `empty`=1.
- Single push `in_out`=4'hA, `in_cout`=0, `in_opcode`=2'b00:
  - Next cycle `out_valid`=1, `out_data`=4'hA, `count`=1.
  - Pop with `out_ready`=1 gives `empty`=1.
- Fill with 4 pushes `out` values 1,2,3,4 while `out_ready`=0:
  - `full`=1, `count`=4.
  - A fifth push `out`=5 sets `overflow`=1, `count` stays 4.
  - Pops return 1,2,3,4 in order.
- While full, push `out`=7 with `out_ready`=1:
  - `count` stays 4 and `overflow` stays 0.
  - The last pop returns 7 after wrap-around.
- Push `{cout,out}`=5'b0_0000 for opcode 2'b10 (A&B with A=0):
  - `out_zero`=1 at the head.
  - `clr_ovf` together with a new overflow leaves `overflow`=1.
- `rst` asserted while `count`=3 and push/pop are active: next cycle `count`=0, `empty`=1, `overflow`=0, head outputs 0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: small result buffer behind the 4-bit ALU stage.
// Each entry holds {opcode, cout, out}. Entries leave through a valid/ready handshake.
// There is no fall-through path: an entry becomes visible in the cycle after its push edge.
// A push into a full buffer with no pop in the same cycle is dropped, and the sticky
// overflow flag is raised.
// Optional feature: define ALU_RES_PARITY_EN to store a parity bit per entry and expose
// it on out_parity.

module alu_result_fifo #(
    parameter int unsigned DATA_W = 4,
    // Must be a power of two and at least 2 so that the pointers wrap naturally.
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_out,
    input  logic                       in_cout,
    input  logic [1:0]                 in_opcode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_cout,
    output logic [1:0]                 out_opcode,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
`ifdef ALU_RES_PARITY_EN
    output logic                       out_parity,
`endif
    input  logic                       clr_ovf
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
`ifdef ALU_RES_PARITY_EN
    localparam int unsigned EntW = DATA_W + 4;
`else
    localparam int unsigned EntW = DATA_W + 3;
`endif
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [EntW-1:0] mem [DEPTH];
    logic [EntW-1:0] entry_in;
    logic [EntW-1:0] head;

    logic is_full;
    logic is_empty;
    logic push;
    logic pop;
    logic drop;

    // Occupancy flags and handshake decode, all derived from registered state.
    always_comb begin
        is_full  = (count_q == CntFull);
        is_empty = (count_q == '0);
        pop      = !is_empty && out_ready;
        // A pop in the same cycle frees a slot, so a full buffer can still accept data.
        push     = in_valid && (!is_full || pop);
        drop     = in_valid && is_full && !pop;
    end

    // Pack the incoming ALU result into an entry. Parity is computed once, at push time.
    always_comb begin
        entry_in = '0;
        entry_in[DATA_W-1:0]        = in_out;
        entry_in[DATA_W]            = in_cout;
        entry_in[DATA_W+2:DATA_W+1] = in_opcode;
`ifdef ALU_RES_PARITY_EN
        entry_in[DATA_W+3]          = ^{in_opcode, in_cout, in_out};
`endif
    end

    // Next-state logic for the pointers, the occupancy count and the sticky overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // When a drop and a clear request arrive together, the set wins.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state register with synchronous reset. A reset discards all buffered entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array. It is not reset. A push in the reset cycle is ignored.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= entry_in;
        end
    end

    // Head presentation. Outputs are forced to zero while the buffer is empty so that stale
    // storage never shows downstream.
    always_comb begin
        head       = is_empty ? '0 : mem[rd_ptr_q];
        out_valid  = !is_empty;
        out_data   = head[DATA_W-1:0];
        out_cout   = head[DATA_W];
        out_opcode = head[DATA_W+2:DATA_W+1];
        out_zero   = !is_empty && ({head[DATA_W], head[DATA_W-1:0]} == '0);
`ifdef ALU_RES_PARITY_EN
        out_parity = head[DATA_W+3];
`endif
        count      = count_q;
        full       = is_full;
        empty      = is_empty;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo.
// A table of per-cycle vectors holds the inputs and the hand-derived head and status
// values for that cycle. A queue scoreboard checks the order of pops. A hand-written
// sequence covers reset in the middle of traffic.

module tb_alu_result_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_out;
    logic       in_cout;
    logic [1:0] in_opcode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_cout;
    logic [1:0] out_opcode;
    logic       out_zero;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;
`ifdef ALU_RES_PARITY_EN
    logic       out_parity;
`endif

    alu_result_fifo #(
        .DATA_W (4),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_out     (in_out),
        .in_cout    (in_cout),
        .in_opcode  (in_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cout   (out_cout),
        .out_opcode (out_opcode),
        .out_zero   (out_zero),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
`ifdef ALU_RES_PARITY_EN
        .out_parity (out_parity),
`endif
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       c;
        logic [1:0] op;
        logic       rdy;
        logic       clr;
        logic [2:0] cnt;
        logic [3:0] hd;
        logic [1:0] hop;
        logic       hz;
        logic       ovf;
    } vec_t;

    typedef struct packed {
        logic [1:0] op;
        logic       c;
        logic [3:0] d;
    } ent_t;

    int   tests;
    int   fails;
    ent_t sb[$];
    logic model_ovf;
    vec_t tbl[21];

    function automatic vec_t mk(logic v, logic [3:0] d, logic c, logic [1:0] op, logic rdy,
                                logic clr, logic [2:0] cnt, logic [3:0] hd, logic [1:0] hop,
                                logic hz, logic ovf);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.op = op; r.rdy = rdy; r.clr = clr;
        r.cnt = cnt; r.hd = hd; r.hop = hop; r.hz = hz; r.ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Apply one vector for one cycle. Check at the falling edge, then let the rising edge land.
    task automatic step(input vec_t v, input int idx);
        ent_t e;
        bit   do_pop;
        in_valid  = v.v;
        in_out    = v.d;
        in_cout   = v.c;
        in_opcode = v.op;
        out_ready = v.rdy;
        clr_ovf   = v.clr;
        @(negedge clk);
        chk($sformatf("row%0d count", idx), 32'(count), 32'(v.cnt));
        chk($sformatf("row%0d out_valid", idx), 32'(out_valid), 32'(v.cnt != 0));
        chk($sformatf("row%0d full", idx), 32'(full), 32'(v.cnt == 4));
        chk($sformatf("row%0d empty", idx), 32'(empty), 32'(v.cnt == 0));
        chk($sformatf("row%0d out_data", idx), 32'(out_data), 32'(v.hd));
        chk($sformatf("row%0d out_opcode", idx), 32'(out_opcode), 32'(v.hop));
        chk($sformatf("row%0d out_zero", idx), 32'(out_zero), 32'(v.hz));
        chk($sformatf("row%0d overflow", idx), 32'(overflow), 32'(v.ovf));
        // Scoreboard: a pop must return the oldest accepted entry.
        do_pop = v.rdy && (sb.size() > 0);
        if (do_pop) begin
            chk($sformatf("row%0d pop entry", idx), 32'({out_opcode, out_cout, out_data}),
                32'(sb[0]));
        end
        if (v.v && sb.size() == 4 && !do_pop) begin
            model_ovf = 1'b1;
        end else if (v.clr) begin
            model_ovf = 1'b0;
        end
        if (v.v && (sb.size() < 4 || do_pop)) begin
            e.op = v.op; e.c = v.c; e.d = v.d;
            sb.push_back(e);
        end
        if (do_pop) begin
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        chk($sformatf("row%0d model count", idx), 32'(count), 32'(sb.size()));
        chk($sformatf("row%0d model overflow", idx), 32'(overflow), 32'(model_ovf));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        model_ovf = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_out    = 4'h0;
        in_cout   = 1'b0;
        in_opcode = 2'b00;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;

        //            v  d     c  op     rdy  clr | cnt hd    hop    hz ovf
        tbl[0]  = mk(0, 4'h0, 0, 2'd0, 0, 0,  3'd0, 4'h0, 2'd0, 0, 0);
        tbl[1]  = mk(1, 4'hA, 0, 2'd0, 0, 0,  3'd0, 4'h0, 2'd0, 0, 0);
        tbl[2]  = mk(0, 4'h0, 0, 2'd0, 1, 0,  3'd1, 4'hA, 2'd0, 0, 0);
        tbl[3]  = mk(1, 4'h1, 0, 2'd1, 0, 0,  3'd0, 4'h0, 2'd0, 0, 0);
        tbl[4]  = mk(1, 4'h2, 0, 2'd1, 0, 0,  3'd1, 4'h1, 2'd1, 0, 0);
        tbl[5]  = mk(1, 4'h3, 0, 2'd1, 0, 0,  3'd2, 4'h1, 2'd1, 0, 0);
        tbl[6]  = mk(1, 4'h4, 0, 2'd1, 0, 0,  3'd3, 4'h1, 2'd1, 0, 0);
        tbl[7]  = mk(1, 4'h5, 0, 2'd1, 0, 0,  3'd4, 4'h1, 2'd1, 0, 0);
        tbl[8]  = mk(0, 4'h0, 0, 2'd0, 0, 1,  3'd4, 4'h1, 2'd1, 0, 1);
        tbl[9]  = mk(1, 4'h7, 1, 2'd3, 1, 0,  3'd4, 4'h1, 2'd1, 0, 0);
        tbl[10] = mk(0, 4'h0, 0, 2'd0, 1, 0,  3'd4, 4'h2, 2'd1, 0, 0);
        tbl[11] = mk(0, 4'h0, 0, 2'd0, 1, 0,  3'd3, 4'h3, 2'd1, 0, 0);
        tbl[12] = mk(0, 4'h0, 0, 2'd0, 1, 0,  3'd2, 4'h4, 2'd1, 0, 0);
        tbl[13] = mk(0, 4'h0, 0, 2'd0, 1, 0,  3'd1, 4'h7, 2'd3, 0, 0);
        tbl[14] = mk(1, 4'h0, 0, 2'd2, 0, 0,  3'd0, 4'h0, 2'd0, 0, 0);
        tbl[15] = mk(1, 4'h1, 0, 2'd0, 0, 0,  3'd1, 4'h0, 2'd2, 1, 0);
        tbl[16] = mk(1, 4'h2, 0, 2'd0, 0, 0,  3'd2, 4'h0, 2'd2, 1, 0);
        tbl[17] = mk(1, 4'h3, 0, 2'd0, 0, 0,  3'd3, 4'h0, 2'd2, 1, 0);
        tbl[18] = mk(1, 4'h9, 0, 2'd0, 0, 1,  3'd4, 4'h0, 2'd2, 1, 0);
        tbl[19] = mk(0, 4'h0, 0, 2'd0, 0, 0,  3'd4, 4'h0, 2'd2, 1, 1);
        tbl[20] = mk(0, 4'h0, 0, 2'd0, 1, 0,  3'd4, 4'h0, 2'd2, 1, 1);

        // Reset state, observed after reset is released and while the inputs are idle.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset head", 32'({out_opcode, out_cout, out_data}), 32'd0);
        chk("reset out_zero", 32'(out_zero), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i], i);
        end

        // Reset with count at 3 while a push and a pop are both requested.
        chk("pre-reset count", 32'(count), 32'd3);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_out    = 4'h5;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        chk("midreset count", 32'(count), 32'd0);
        chk("midreset empty", 32'(empty), 32'd1);
        chk("midreset overflow", 32'(overflow), 32'd0);
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset head", 32'({out_opcode, out_cout, out_data, out_zero}), 32'd0);
        @(posedge clk);
        #1;

        // The buffer works normally again after the reset.
        step(mk(1, 4'h6, 1, 2'd1, 0, 0, 3'd0, 4'h0, 2'd0, 0, 0), 21);
        step(mk(0, 4'h0, 0, 2'd0, 1, 0, 3'd1, 4'h6, 2'd1, 0, 0), 22);
        step(mk(0, 4'h0, 0, 2'd0, 0, 0, 3'd0, 4'h0, 2'd0, 0, 0), 23);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
